baud_gen_frac: RTL



---
 rtl/baud_pkg.sv | 29 ++
 rtl/baud_gen_frac.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/baud_pkg.sv
// Shared baud-generator constants: divisor widths, default oversample, standard rates.
// Latency: n/a (constants only).
// Backpressure: n/a.
package baud_pkg;

  localparam int DEFAULT_DIV_INT_W  = 16;
  localparam int DEFAULT_FRAC_W     = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Integer divisors below this are clamped up; a 1-clk period cannot produce a pulse.
  localparam int MIN_DIV_INT = 2;

  typedef struct packed {
    logic [DEFAULT_DIV_INT_W-1:0] div_int;
    logic [DEFAULT_FRAC_W-1:0]    div_frac;
  } baud_div_t;

  // 100 MHz clock, x16 oversample: divisor = 1e8 / (16 * baud), fraction in 1/256 units.
  localparam baud_div_t BAUD_600    = '{div_int: 16'd10416, div_frac: 8'd171};
  localparam baud_div_t BAUD_1200   = '{div_int: 16'd5208,  div_frac: 8'd85};
  localparam baud_div_t BAUD_2400   = '{div_int: 16'd2604,  div_frac: 8'd43};
  localparam baud_div_t BAUD_4800   = '{div_int: 16'd1302,  div_frac: 8'd21};
  localparam baud_div_t BAUD_9600   = '{div_int: 16'd651,   div_frac: 8'd11};
  localparam baud_div_t BAUD_19200  = '{div_int: 16'd325,   div_frac: 8'd133};
  localparam baud_div_t BAUD_38400  = '{div_int: 16'd162,   div_frac: 8'd195};
  localparam baud_div_t BAUD_57600  = '{div_int: 16'd108,   div_frac: 8'd130};
  localparam baud_div_t BAUD_115200 = '{div_int: 16'd54,    div_frac: 8'd65};

endpackage

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick every div_int(+1) clk, bit_tick every OVERSAMPLE ticks.
// Latency: tick/bit_tick are registered, high the clk after the terminal count; new divisor lands at a period boundary.
// Backpressure: none; enable=0 freezes the phase, resync restarts it.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int DIV_INT_W      = DEFAULT_DIV_INT_W,
  parameter int FRAC_W         = DEFAULT_FRAC_W,
  parameter int OVERSAMPLE     = DEFAULT_OVERSAMPLE,
  parameter int RESET_DIV_INT  = 651,
  parameter int RESET_DIV_FRAC = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 resync,
  input  logic                 div_wr,
  input  logic [DIV_INT_W-1:0] div_int_in,
  input  logic [FRAC_W-1:0]    div_frac_in,
  output logic                 div_pending,
  output logic                 tick,
  output logic                 bit_tick
);

  localparam int                   SUB_W    = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [DIV_INT_W-1:0] DIV_MIN  = DIV_INT_W'(MIN_DIV_INT);

  logic [DIV_INT_W-1:0] cnt_q, cnt_d;
  logic [FRAC_W-1:0]    acc_q, acc_d;
  logic                 extra_q, extra_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [DIV_INT_W-1:0] div_int_q, div_int_d;
  logic [FRAC_W-1:0]    div_frac_q, div_frac_d;
  logic [DIV_INT_W-1:0] shd_int_q, shd_int_d;
  logic [FRAC_W-1:0]    shd_frac_q, shd_frac_d;
  logic                 pend_q, pend_d;
  logic                 tick_q, tick_d;
  logic                 bit_tick_q, bit_tick_d;

  logic [DIV_INT_W-1:0] eff_int;
  logic [DIV_INT_W:0]   period_m1;
  logic                 at_term;
  logic [FRAC_W:0]      acc_sum;

  // Period length is the clamped integer divisor plus the carry earned by the previous period.
  // The >= compare keeps the counter from running away if a smaller divisor lands mid-period.
  assign eff_int   = (div_int_q < DIV_MIN) ? DIV_MIN : div_int_q;
  assign period_m1 = {1'b0, eff_int} + {{DIV_INT_W{1'b0}}, extra_q} - {{DIV_INT_W{1'b0}}, 1'b1};
  assign at_term   = ({1'b0, cnt_q} >= period_m1);
  assign acc_sum   = {1'b0, acc_q} + {1'b0, div_frac_q};

  // Next-state: resync beats divisor apply beats counting; a write always lands in the shadow.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    extra_d    = extra_q;
    sub_d      = sub_q;
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    bit_tick_d = 1'b0;

    if (resync) begin
      cnt_d   = '0;
      acc_d   = '0;
      extra_d = 1'b0;
      sub_d   = '0;
      if (pend_q) begin
        div_int_d  = shd_int_q;
        div_frac_d = shd_frac_q;
        pend_d     = 1'b0;
      end
    end else if (pend_q && !enable) begin
      // Idle generator has no boundary to wait for, so swap the divisor straight away.
      div_int_d  = shd_int_q;
      div_frac_d = shd_frac_q;
      acc_d      = '0;
      extra_d    = 1'b0;
      pend_d     = 1'b0;
    end else if (enable) begin
      if (at_term) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        if (sub_q == SUB_LAST) begin
          sub_d      = '0;
          bit_tick_d = 1'b1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
        if (pend_q) begin
          div_int_d  = shd_int_q;
          div_frac_d = shd_frac_q;
          acc_d      = '0;
          extra_d    = 1'b0;
          pend_d     = 1'b0;
        end else begin
          acc_d   = acc_sum[FRAC_W-1:0];
          extra_d = acc_sum[FRAC_W];
        end
      end else begin
        cnt_d = cnt_q + DIV_INT_W'(1);
      end
    end

    if (div_wr) begin
      shd_int_d  = div_int_in;
      shd_frac_d = div_frac_in;
      pend_d     = 1'b1;
    end
  end

  // State and output registers with synchronous reset to the default divisor.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      extra_q    <= 1'b0;
      sub_q      <= '0;
      div_int_q  <= DIV_INT_W'(RESET_DIV_INT);
      div_frac_q <= FRAC_W'(RESET_DIV_FRAC);
      shd_int_q  <= DIV_INT_W'(RESET_DIV_INT);
      shd_frac_q <= FRAC_W'(RESET_DIV_FRAC);
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      extra_q    <= extra_d;
      sub_q      <= sub_d;
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign div_pending = pend_q;
  assign tick        = tick_q;
  assign bit_tick    = bit_tick_q;

endmodule
